conv_window_valid_gen: RTL
==========================

Name: conv_window_valid_gen

Overview:
Streaming pixel-position tracker for the convolution datapath. It counts raster-order pixel strobes over a frame of IMG_WIDTH x IMG_HEIGHT and flags each pixel at which a complete KERNEL x KERNEL window, aligned to STRIDE, ends. For every such pixel it also reports the output-feature-map coordinate and end-of-line and end-of-frame strobes. It sits between the line buffers and the MAC array, and replaces the fixed 3x3, stride-1 pixel counter.

Parameters:
IMG_WIDTH, 220, pixels per line (>= KERNEL)
IMG_HEIGHT, 220, lines per frame (>= KERNEL)
KERNEL, 3, window side length (>= 1)
STRIDE, 1, window step in both axes (>= 1)
CW, $clog2(IMG_WIDTH), column/output-column index width (derived, localparam)
RW, $clog2(IMG_HEIGHT), row/output-row index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
Data_In  in  1  pixel-valid strobe, one pixel per high cycle
Data_Out  out  1  window valid; registered, high for one cycle per valid window
out_col  out  CW  output-map column of the current Data_Out
out_row  out  RW  output-map row of the current Data_Out
line_done  out  1  pulse with the last valid window of an output row
frame_done  out  1  pulse on the cycle after the last pixel of the frame is accepted

Behaviour:
- Reset is one clock, synchronous, active-low: rst sampled low at a rising edge.
- On reset, all of the following are cleared to 0: col/row counters, stride phase counters, out_col, out_row, Data_Out, line_done, frame_done.
- Reset mid-frame abandons the frame. The next accepted pixel is (0,0).
- Internal state:
  - col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1: position of the next pixel.
  - cph and rph 0..STRIDE-1: stride phase counters.
  - ocol and orow: next output coordinates.
- Data_In low: all counters hold. Data_Out, line_done and frame_done are 0 next cycle. Gaps of any length are legal.
- Data_In high at position (col,row) is a window hit when all of these hold:
  - col >= KERNEL-1
  - row >= KERNEL-1
  - cph == 0
  - rph == 0
- On a window hit, the next cycle (latency 1) gives:
  - Data_Out = 1
  - out_col = ocol, out_row = orow
  - ocol increments after the hit.
- cph behaviour:
  - Resets to 0 at col == KERNEL-1.
  - Increments for col > KERNEL-1, wrapping at STRIDE-1.
  - Modulo/divide operators are forbidden; phase counters only.
- rph behaviour:
  - Same rule as cph, applied at end of line, for row >= KERNEL-1.
- line_done = 1 with the last hit of a line; ocol returns to 0 when it is asserted.
- orow increments at the end of any line that produced hits.
- Output map dimensions are exact:
  - Columns: OW = (IMG_WIDTH-KERNEL)/STRIDE + 1
  - Rows: OH = (IMG_HEIGHT-KERNEL)/STRIDE + 1
  - Trailing columns/rows that cannot host an aligned window produce no hit.
- End of line (col == IMG_WIDTH-1 accepted):
  - col -> 0
  - row increments
- End of frame (col == IMG_WIDTH-1 and row == IMG_HEIGHT-1 accepted):
  - row, col, phases, ocol and orow all -> 0.
  - frame_done = 1 next cycle.
  - A pixel on the following cycle is (0,0) of the next frame; no bubble is required.
- The last pixel of a frame can be a hit. Data_Out, line_done and frame_done may then assert in the same cycle.
- KERNEL == 1 and STRIDE == 1: every pixel is a hit.
- Counters never exceed their bounds; no wrap other than the frame wrap.

Optional Feature:
Macro: CONV_SOF_SYNC_EN.

Defined:
- Adds input sof (1 bit) and output sof_err (1 bit, reset 0).
- sof high with Data_In high forces that pixel to be treated as (0,0) of a new frame. All counters restart before the hit evaluation.
- If that pixel was not already at (0,0), sof_err pulses for 1 cycle on the next cycle, and no frame_done is issued for the truncated frame.
- sof without Data_In is ignored.

Undefined:
- Ports are absent.
- Frame alignment comes from reset and counting only.

Test Plan:
1. W=8, H=6, K=3, S=1, 48 back-to-back pixels:
   - Exactly 24 Data_Out pulses.
   - First Data_Out the cycle after pixel 18 (col=2, row=2), with out=(0,0).
   - Last Data_Out with out=(5,3), coincident with line_done and frame_done.
2. W=8, H=6, K=3, S=2:
   - 6 hits at pixel (col,row) in {2,4,6} x {2,4}.
   - out_col 0..2, out_row 0..1.
   - line_done on the hits at col 6; frame_done after pixel 47.
3. Same as scenario 1, with Data_In toggled on a random 40% duty:
   - Hit sequence and coordinates are identical to scenario 1.
   - No outputs during gaps.
4. Two frames back-to-back with no gap:
   - frame_done pulses once per frame.
   - Second frame's first hit again at out=(0,0), 24 hits each.
5. Reset asserted at pixel 30 of a frame, then 48 pixels:
   - During reset, all outputs are 0.
   - Afterwards, a clean 24-hit frame.
6. CONV_SOF_SYNC_EN defined, sof issued at pixel 20:
   - sof_err pulses once.
   - Next 48 pixels yield 24 hits and one frame_done.
   - sof at a true (0,0) gives no sof_err.

Source files
------------

// File: rtl/conv_window_valid_gen.sv
// conv_window_valid_gen
//   Tracks the raster position of a pixel stream over an IMG_WIDTH x IMG_HEIGHT
//   frame. It flags every pixel that ends a complete KERNEL x KERNEL window
//   aligned to STRIDE. For each such window it reports the output-map
//   coordinate, plus end-of-line and end-of-frame strobes.
//
//   Stream contract: the stream has no back-pressure. A high Data_In accepts
//   exactly one pixel on that clock edge. A low Data_In is a gap of any
//   length, and all position state holds through it. Every output is
//   registered and follows the accepting edge by one cycle.
//
//   Ports:
//     clk        clock
//     rst        synchronous active-low reset
//     Data_In    pixel-valid strobe
//     Data_Out   window valid (one-cycle pulse per window)
//     out_col    output-map column of the current Data_Out
//     out_row    output-map row of the current Data_Out
//     line_done  pulse with the last window of an output row
//     frame_done pulse after the last pixel of the frame is accepted
//
//   Optional (macro CONV_SOF_SYNC_EN):
//     sof        start-of-frame marker, qualified by Data_In
//     sof_err    pulse when sof arrived at a pixel other than (0,0)
module conv_window_valid_gen #(
   parameter int IMG_WIDTH  = 220,
   parameter int IMG_HEIGHT = 220,
   parameter int KERNEL     = 3,
   parameter int STRIDE     = 1,
   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          Data_In,
`ifdef CONV_SOF_SYNC_EN
   input  logic          sof,
   output logic          sof_err,
`endif
   output logic          Data_Out,
   output logic [CW-1:0] out_col,
   output logic [RW-1:0] out_row,
   output logic          line_done,
   output logic          frame_done
);

   localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int OW = (IMG_WIDTH - KERNEL) / STRIDE + 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_K1    = CW'(KERNEL - 1);
   localparam logic [RW-1:0] ROW_K1    = RW'(KERNEL - 1);
   localparam logic [CW-1:0] OCOL_LAST = CW'(OW - 1);
   localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

   // Position of the next pixel, stride phases and next output coordinate.
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] cph;
   logic [PW-1:0] rph;
   logic [CW-1:0] ocol;
   logic [RW-1:0] orow;

   // Effective state seen by the current pixel. A start-of-frame marker
   // replaces it with the frame origin before the hit is evaluated.
   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic [PW-1:0] cp;
   logic [PW-1:0] rp;
   logic [CW-1:0] oc;
   logic [RW-1:0] orr;
   logic          hit;
   logic          last_hit;
   logic          eol;
   logic          eof;

   always_comb begin
      c   = col;
      r   = row;
      cp  = cph;
      rp  = rph;
      oc  = ocol;
      orr = orow;
`ifdef CONV_SOF_SYNC_EN
      if (sof) begin
         c   = '0;
         r   = '0;
         cp  = '0;
         rp  = '0;
         oc  = '0;
         orr = '0;
      end
`endif
      hit      = (c >= COL_K1) && (r >= ROW_K1) && (cp == '0) && (rp == '0);
      last_hit = hit && (oc == OCOL_LAST);
      eol      = (c == COL_LAST);
      eof      = eol && (r == ROW_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         col        <= '0;
         row        <= '0;
         cph        <= '0;
         rph        <= '0;
         ocol       <= '0;
         orow       <= '0;
         out_col    <= '0;
         out_row    <= '0;
         Data_Out   <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
`ifdef CONV_SOF_SYNC_EN
         sof_err    <= 1'b0;
`endif
      end else begin
         Data_Out   <= 1'b0;
         line_done  <= 1'b0;
         frame_done <= 1'b0;
`ifdef CONV_SOF_SYNC_EN
         sof_err    <= 1'b0;
`endif
         if (Data_In) begin
`ifdef CONV_SOF_SYNC_EN
            sof_err <= sof && !((col == '0) && (row == '0));
`endif
            if (hit) begin
               Data_Out  <= 1'b1;
               out_col   <= oc;
               out_row   <= orr;
               line_done <= last_hit;
            end

            if (eof) begin
               col        <= '0;
               row        <= '0;
               cph        <= '0;
               rph        <= '0;
               ocol       <= '0;
               orow       <= '0;
               frame_done <= 1'b1;
            end else if (eol) begin
               col  <= '0;
               row  <= r + 1'b1;
               cph  <= '0;
               ocol <= '0;
               // Row phase only starts advancing once the first full
               // window row has been reached.
               if (r < ROW_K1)
                  rph <= '0;
               else
                  rph <= (rp == PH_LAST) ? '0 : rp + 1'b1;
               // Only lines that produced windows advance the output row.
               if ((r >= ROW_K1) && (rp == '0))
                  orow <= orr + 1'b1;
               else
                  orow <= orr;
            end else begin
               col  <= c + 1'b1;
               row  <= r;
               rph  <= rp;
               orow <= orr;
               if (c < COL_K1)
                  cph <= '0;
               else
                  cph <= (cp == PH_LAST) ? '0 : cp + 1'b1;
               if (hit)
                  ocol <= last_hit ? '0 : oc + 1'b1;
               else
                  ocol <= oc;
            end
         end
      end
   end

endmodule
